fetch_ctrl: RTL and testbench

Instruction-fetch stage controller. It holds the architectural PC register, turns the selected next PC into instruction-bus requests, and delivers `{pc, instr}` into the fetch/decode pipeline register. It sits directly downstream of the PC-select stage: it consumes that stage's `pc_selected`/`move` and feeds it back `pcplus4` and `stop_forfetch`.

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch stage controller: owns the PC, issues instruction-bus
// requests and loads {pc, instr} into the fetch/decode pipeline register.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] pc_selected,
    input  logic        move,
    input  logic        branch,
    input  logic        fd_hold,
    output logic [63:0] pcplus4,
    output logic        stop_forfetch,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        fd_valid,
    output logic [63:0] fd_pc,
    output logic [31:0] fd_instr,
    output logic        fd_exc
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_addr;
    logic [31:0] r_inst_buf;
    logic        r_exc_buf;

    logic        w_in_fetch;
    logic        w_in_hold;
    logic        w_in_discard;
    logic        w_mis;
    logic        w_avail;
    logic [31:0] w_cur_instr;

    assign w_in_fetch   = (r_state == ST_FETCH);
    assign w_in_hold    = (r_state == ST_HOLD);
    assign w_in_discard = (r_state == ST_DISCARD);
    assign w_mis        = (r_pc[1:0] != 2'b00);

    // A misaligned PC never goes to the bus; its NOP is available at once.
    assign w_avail     = (w_in_fetch && (w_mis || iresp_data_ok)) || w_in_hold;
    assign w_cur_instr = w_mis ? NOP_INSTR : (w_in_hold ? r_inst_buf : iresp_data);

    assign pcplus4       = r_pc + 64'd4;
    assign stop_forfetch = !w_avail;
    assign ireq_valid    = resetn && ((w_in_fetch && !w_mis) || w_in_discard);
    assign ireq_addr     = r_req_addr;

    // PC, request address, held-instruction buffer and fetch state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_inst_buf <= '0;
            r_exc_buf  <= 1'b0;
        end else begin
            if (move) begin
                r_pc <= pc_selected;
            end
            case (r_state)
                ST_FETCH: begin
                    if (move) begin
                        if (w_avail) begin
                            r_req_addr <= pc_selected;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (w_avail) begin
                        r_state    <= ST_HOLD;
                        r_inst_buf <= w_cur_instr;
                        r_exc_buf  <= w_mis;
                    end
                end
                ST_HOLD: begin
                    if (move) begin
                        r_state    <= ST_FETCH;
                        r_req_addr <= pc_selected;
                    end
                end
                ST_DISCARD: begin
                    // Stale response is dropped; refetch at the newest PC.
                    if (iresp_data_ok) begin
                        r_state    <= ST_FETCH;
                        r_req_addr <= move ? pc_selected : r_pc;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // F/D pipeline register: squash, hold, load, else bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fd_valid <= 1'b0;
            fd_pc    <= '0;
            fd_instr <= '0;
            fd_exc   <= 1'b0;
        end else if (move && branch) begin
            fd_valid <= 1'b0;
        end else if (fd_hold) begin
            fd_valid <= fd_valid;
        end else if (move && !w_in_discard) begin
            fd_valid <= 1'b1;
            fd_pc    <= r_pc;
            fd_instr <= w_cur_instr;
            fd_exc   <= w_in_hold ? r_exc_buf : w_mis;
        end else begin
            fd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: wait-programmable bus slave, queue scoreboard of
// expected F/D contents, and per-scenario directed checks.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fd_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] pc_selected;
    logic        move;
    logic        branch;
    logic        fd_hold;
    logic [63:0] pcplus4;
    logic        stop_forfetch;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fd_valid;
    logic [63:0] fd_pc;
    logic [31:0] fd_instr;
    logic        fd_exc;

    logic        auto_mode;
    logic        man_move;
    logic        man_branch;
    logic [63:0] man_pcsel;
    int unsigned bus_wait;
    int unsigned wcnt;

    int          n_checks = 0;
    int          n_errors = 0;
    fd_t         sb_q[$];
    logic [63:0] model_pc;
    logic        held;
    logic [63:0] held_addr;

    fetch_ctrl dut (
        .clk(clk), .resetn(resetn), .pc_selected(pc_selected), .move(move),
        .branch(branch), .fd_hold(fd_hold), .pcplus4(pcplus4),
        .stop_forfetch(stop_forfetch), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .fd_valid(fd_valid),
        .fd_pc(fd_pc), .fd_instr(fd_instr), .fd_exc(fd_exc)
    );

    always #5 clk = ~clk;

    // PC-select stand-in: sequential fetch in auto mode, scripted otherwise.
    assign move        = auto_mode ? !stop_forfetch : man_move;
    assign pc_selected = auto_mode ? pcplus4 : man_pcsel;
    assign branch      = auto_mode ? 1'b0 : man_branch;

    // Bus slave: answers after bus_wait cycles with instr = addr[31:0].
    assign iresp_data_ok = ireq_valid && (wcnt >= bus_wait);
    assign iresp_data    = ireq_addr[31:0];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) wcnt <= 0;
        else if (ireq_valid && !iresp_data_ok) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                model_pc = RESET_PC;
                held     = 1'b0;
                sb_q.delete();
            end else begin
                assert (!(move && !branch && fd_hold)) else $error("illegal move with fd_hold");
                if (move && !branch && !stop_forfetch && !fd_hold) begin
                    if (model_pc[1:0] != 2'b00) sb_q.push_back('{model_pc, NOP, 1'b1});
                    else sb_q.push_back('{model_pc, model_pc[31:0], 1'b0});
                end
                held      = ireq_valid && !iresp_data_ok;
                held_addr = ireq_addr;
                if (move) model_pc = pc_selected;
            end
        end
    endtask

    task automatic sb_check();
        fd_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (fd_valid) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: got fd_valid=1 pc=%h expected fd_valid=0", fd_pc);
                    end else begin
                        e = sb_q.pop_front();
                        if ({fd_pc, fd_instr, fd_exc} !== e) begin
                            n_errors++;
                            $display("FAIL sb_fd: got pc=%h instr=%h exc=%b expected pc=%h instr=%h exc=%b",
                                     fd_pc, fd_instr, fd_exc, e.pc, e.instr, e.exc);
                        end
                    end
                end else if (sb_q.size() != 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_missing: got fd_valid=0 expected pc=%h", sb_q[0].pc);
                    sb_q.delete();
                end
                if (held && ireq_valid) begin
                    n_checks++;
                    if (ireq_addr !== held_addr) begin
                        n_errors++;
                        $display("FAIL bus_addr_stable: got %h expected %h", ireq_addr, held_addr);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        auto_mode = 1'b1; man_move = 1'b0; man_branch = 1'b0; man_pcsel = '0;
        bus_wait = 0; fd_hold = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        n_checks++; if ({fd_pc, fd_instr, fd_exc} !== 97'd0) begin n_errors++;
            $display("FAIL rst_fd_fields: got pc=%h instr=%h exc=%b expected 0", fd_pc, fd_instr, fd_exc); end
        n_checks++; if (pcplus4 !== RESET_PC + 64'd4) begin n_errors++;
            $display("FAIL rst_pcplus4: got %h expected %h", pcplus4, RESET_PC + 64'd4); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ireq_valid !== 1'b0 || fd_valid !== 1'b0) begin n_errors++;
                $display("FAIL rst_valids: got ireq_valid=%b fd_valid=%b expected 0 0", ireq_valid, fd_valid); end
            tick();
        end
        resetn = 1'b1;
        #1;
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC || stop_forfetch !== 1'b0) begin n_errors++;
            $display("FAIL first_req: got valid=%b addr=%h stop=%b expected 1 %h 0", ireq_valid, ireq_addr, stop_forfetch, RESET_PC); end
        tick();
        n_checks++; if (ireq_addr !== 64'h8000_0004) begin n_errors++;
            $display("FAIL second_req: got %h expected 8000_0004", ireq_addr); end
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== RESET_PC || fd_instr !== 32'h8000_0000) begin n_errors++;
            $display("FAIL first_fd: got v=%b pc=%h instr=%h expected 1 %h 80000000", fd_valid, fd_pc, fd_instr, RESET_PC); end
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        for (int i = 1; i < 8; i++) begin
            tick();
            e = 32'h8000_0000 + 32'(4 * i);
            n_checks++; if (fd_valid !== 1'b1 || fd_instr !== e) begin n_errors++;
                $display("FAIL stream_%0d: got v=%b instr=%h expected 1 %h", i, fd_valid, fd_instr, e); end
        end
    endtask

    task automatic test_hold();
        auto_mode = 1'b0; man_move = 1'b0; man_branch = 1'b0;
        #1;
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0020 || stop_forfetch !== 1'b0) begin n_errors++;
            $display("FAIL hold_pre: got valid=%b addr=%h stop=%b expected 1 80000020 0", ireq_valid, ireq_addr, stop_forfetch); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (ireq_valid !== 1'b0 || stop_forfetch !== 1'b0 || fd_valid !== 1'b0) begin n_errors++;
                $display("FAIL hold_state_%0d: got ireq_valid=%b stop=%b fd_valid=%b expected 0 0 0", k, ireq_valid, stop_forfetch, fd_valid); end
        end
        man_move = 1'b1; man_pcsel = 64'h8000_0024;
        #1;
        n_checks++; if (pcplus4 !== 64'h8000_0024) begin n_errors++;
            $display("FAIL hold_pcplus4: got %h expected 80000024", pcplus4); end
        tick();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_0020 || fd_instr !== 32'h8000_0020) begin n_errors++;
            $display("FAIL hold_release_fd: got v=%b pc=%h instr=%h expected 1 80000020 80000020", fd_valid, fd_pc, fd_instr); end
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0024) begin n_errors++;
            $display("FAIL hold_next_req: got valid=%b addr=%h expected 1 80000024", ireq_valid, ireq_addr); end
    endtask

    task automatic test_redirect();
        man_move = 1'b1; man_branch = 1'b1; man_pcsel = 64'h8000_0008;
        tick();
        n_checks++; if (fd_valid !== 1'b0 || ireq_addr !== 64'h8000_0008) begin n_errors++;
            $display("FAIL redir_setup: got fd_valid=%b addr=%h expected 0 80000008", fd_valid, ireq_addr); end
        bus_wait = 3; man_move = 1'b0; man_branch = 1'b0;
        #1;
        n_checks++; if (ireq_valid !== 1'b1 || stop_forfetch !== 1'b1) begin n_errors++;
            $display("FAIL redir_wait: got valid=%b stop=%b expected 1 1", ireq_valid, stop_forfetch); end
        tick();
        man_move = 1'b1; man_branch = 1'b1; man_pcsel = 64'h8000_0100;
        tick();
        man_move = 1'b0; man_branch = 1'b0;
        #1;
        n_checks++; if (ireq_addr !== 64'h8000_0008 || stop_forfetch !== 1'b1 || fd_valid !== 1'b0) begin n_errors++;
            $display("FAIL redir_discard: got addr=%h stop=%b fd_valid=%b expected 80000008 1 0", ireq_addr, stop_forfetch, fd_valid); end
        n_checks++; if (pcplus4 !== 64'h8000_0104) begin n_errors++;
            $display("FAIL redir_pc: got pcplus4=%h expected 80000104", pcplus4); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008 || stop_forfetch !== 1'b1 || iresp_data_ok !== 1'b1) begin n_errors++;
            $display("FAIL redir_stale_resp: got valid=%b addr=%h stop=%b ok=%b expected 1 80000008 1 1", ireq_valid, ireq_addr, stop_forfetch, iresp_data_ok); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100 || fd_valid !== 1'b0) begin n_errors++;
            $display("FAIL redir_new_req: got valid=%b addr=%h fd_valid=%b expected 1 80000100 0", ireq_valid, ireq_addr, fd_valid); end
        bus_wait = 0;
    endtask

    task automatic test_misaligned();
        man_move = 1'b1; man_branch = 1'b1; man_pcsel = 64'h8000_0102;
        tick();
        n_checks++; if (ireq_valid !== 1'b0 || stop_forfetch !== 1'b0 || fd_valid !== 1'b0) begin n_errors++;
            $display("FAIL mis_noreq: got ireq_valid=%b stop=%b fd_valid=%b expected 0 0 0", ireq_valid, stop_forfetch, fd_valid); end
        man_branch = 1'b0; man_pcsel = 64'h8000_0106;
        tick();
        n_checks++; if (fd_valid !== 1'b1 || fd_exc !== 1'b1 || fd_instr !== NOP || fd_pc !== 64'h8000_0102) begin n_errors++;
            $display("FAIL mis_fd: got v=%b exc=%b instr=%h pc=%h expected 1 1 %h 80000102", fd_valid, fd_exc, fd_instr, fd_pc, NOP); end
        n_checks++; if (ireq_valid !== 1'b0) begin n_errors++;
            $display("FAIL mis_noreq2: got %b expected 0", ireq_valid); end
    endtask

    task automatic test_reset_mid();
        man_move = 1'b1; man_branch = 1'b1; man_pcsel = 64'h8000_0200;
        tick();
        bus_wait = 2; man_move = 1'b0; man_branch = 1'b0;
        #1;
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200 || stop_forfetch !== 1'b1) begin n_errors++;
            $display("FAIL rmid_req: got valid=%b addr=%h stop=%b expected 1 80000200 1", ireq_valid, ireq_addr, stop_forfetch); end
        tick();
        man_move = 1'b1; man_branch = 1'b1; man_pcsel = 64'h8000_0300;
        tick();
        man_move = 1'b0; man_branch = 1'b0;
        #1;
        n_checks++; if (ireq_addr !== 64'h8000_0200 || stop_forfetch !== 1'b1) begin n_errors++;
            $display("FAIL rmid_discard: got addr=%h stop=%b expected 80000200 1", ireq_addr, stop_forfetch); end
        resetn = 1'b0;
        #1;
        n_checks++; if (ireq_valid !== 1'b0 || fd_valid !== 1'b0 || pcplus4 !== RESET_PC + 64'd4) begin n_errors++;
            $display("FAIL rmid_async: got ireq_valid=%b fd_valid=%b pcplus4=%h expected 0 0 %h", ireq_valid, fd_valid, pcplus4, RESET_PC + 64'd4); end
        tick();
        auto_mode = 1'b1; bus_wait = 0; resetn = 1'b1;
        #1;
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin n_errors++;
            $display("FAIL rmid_restart: got valid=%b addr=%h expected 1 %h", ireq_valid, ireq_addr, RESET_PC); end
        tick();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== RESET_PC) begin n_errors++;
            $display("FAIL rmid_refill: got v=%b pc=%h expected 1 %h", fd_valid, fd_pc, RESET_PC); end
        resetn = 1'b0;
        #1;
        n_checks++; if (fd_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_errors++;
            $display("FAIL rmid_async_fd: got fd_valid=%b ireq_valid=%b expected 0 0", fd_valid, ireq_valid); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        fork
            sb_push();
            sb_check();
        join_none
        test_reset();
        test_streaming();
        test_hold();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
